regop_sequencer: RTL and testbench
==================================

Name: regop_sequencer

Overview:
- Multi-cycle micro-sequencer for the 4 x 16-bit register-op datapath (r0..r3).
- Loads r0..r3 from the operand inputs, then executes a stored program of register ops, one per cycle.
- Publishes r3..r0 on y3..y0 with a done pulse.
- Lets one datapath instance run arbitrary evolved op sequences without re-synthesis.

Parameters:
- PROG_DEPTH, 16, number of instruction slots (power of 2, 2..256).
- AW, $clog2(PROG_DEPTH), program address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- prog_we  in  1  program write strobe.
- prog_addr  in  AW  program write address.
- prog_data  in  7  instruction: [6:4] op, [3:2] dst, [1:0] src.
- start  in  1  run request, sampled in IDLE only.
- a1, a0, b1, b0  in  16 each  operands, captured in LOAD.
- busy  out  1  high in LOAD, EXEC, DONE.
- done  out  1  one-cycle completion pulse.
- y3, y2, y1, y0  out  16 each  registered results.

Behaviour:
- Reset: async, active-low, one clock, asynchronous assert.
  - State IDLE; pc=0; r0..r3=0; y0..y3=0; busy=0; done=0.
  - Program memory is NOT reset; unwritten slots are undefined. Software writes HALT.
- Opcodes (rd=r[dst], rs=r[src]):
  - 0 NOP.
  - 1 MOV: rd=rs.
  - 2 LNOT: rd={15'b0, rs==0}.
  - 3 OR: rd=rd|rs.
  - 4 AND: rd=rd&rs.
  - 5 XOR: rd=rd^rs.
  - 6 HALT: no register change.
  - 7 BNOT: rd=~rs.
- Ops read pre-edge values. dst==src is legal, e.g. XOR r2,r2 gives 0.
- FSM:
  - IDLE: on start=1 -> LOAD at next edge.
  - LOAD: r0=a0, r1=a1, r2=b0, r3=b1; pc=0; -> EXEC.
  - EXEC: each edge executes instr[pc] and pc++.
    - If the op is HALT, or pc==PROG_DEPTH-1 (last slot executed), -> DONE.
    - On that same edge y3..y0 take the post-instruction r3..r0.
  - DONE: done=1 for exactly this cycle; -> IDLE.
- Latency: with N instructions executed (HALT included), done is high in the cycle after the (N+1)th edge following the start-sampling edge. busy is high for N+2 cycles.
- Operands a*/b* are sampled only in LOAD; changes during EXEC have no effect.
- y* hold their values until the next run's DONE transition.
- start while busy: ignored, no queuing.
- start held high continuously: a new run begins from IDLE, so runs are back-to-back separated by one IDLE cycle.
- prog_we:
  - Honoured in IDLE only; ignored while busy, so the program is stable during a run.
  - Write and start in the same IDLE cycle: the write commits; the run uses the new word.
- pc wraps never: execution stops at the last slot even with no HALT.
- Reset mid-run: immediate abort to the reset values above. No done pulse. Program contents retained.

Test Plan:
- Program [LNOT r3,r0; LNOT r0,r0; OR r0,r3; XOR r2,r2; AND r3,r1; HALT] with a0=0, a1=FFFF, b0=1234, b1=5678, start -> y3=0001, y2=0000, y1=FFFF, y0=0001; done high in the 7th cycle after the start edge; busy 8 cycles.
- Same program, a0=0005, a1=00F0 -> y3=0000, y2=0000, y1=00F0, y0=0000; outputs unchanged until done.
- All 16 slots NOP, start -> stops after the 16th slot; y0..y3 = a0, a1, b0, b1; done after the 17th edge.
- start pulsed and prog_we asserted during EXEC -> neither has effect; one done only; program readback by rerun matches the original.
- [BNOT r1,r0; MOV r2,r1; HALT], a0=00FF -> y1=FF00, y2=FF00, y0=00FF, y3=b1.
- rst_n low during EXEC -> outputs immediately 0, busy=0, no done; new start reruns the stored program correctly.

Source files
------------

// File: rtl/regop_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : regop_sequencer_if                                                |
// | Desc   : Program-load, run-control, operand and result bundle for the      |
// |          register-op micro-sequencer.                                      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface regop_sequencer_if #(
  parameter int PROG_DEPTH = 16,
  parameter int AW         = $clog2(PROG_DEPTH)
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [6:0]    prog_data;
  logic          start;
  logic [15:0]   a1;
  logic [15:0]   a0;
  logic [15:0]   b1;
  logic [15:0]   b0;
  logic          busy;
  logic          done;
  logic [15:0]   y3;
  logic [15:0]   y2;
  logic [15:0]   y1;
  logic [15:0]   y0;

  modport master (
    output prog_we, prog_addr, prog_data, start, a1, a0, b1, b0,
    input  busy, done, y3, y2, y1, y0
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, a1, a0, b1, b0,
    output busy, done, y3, y2, y1, y0
  );
endinterface
`default_nettype wire

// File: rtl/regop_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : regop_sequencer                                                   |
// | Desc   : Loads r0..r3 from operands, executes a stored register-op program |
// |          one instruction per cycle, publishes results with a done pulse.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module regop_sequencer #(
  parameter int PROG_DEPTH = 16,
  parameter int AW         = $clog2(PROG_DEPTH)
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  regop_sequencer_if.slave   bus
);

  localparam logic [2:0] c_OP_NOP  = 3'd0;
  localparam logic [2:0] c_OP_MOV  = 3'd1;
  localparam logic [2:0] c_OP_LNOT = 3'd2;
  localparam logic [2:0] c_OP_OR   = 3'd3;
  localparam logic [2:0] c_OP_AND  = 3'd4;
  localparam logic [2:0] c_OP_XOR  = 3'd5;
  localparam logic [2:0] c_OP_HALT = 3'd6;
  localparam logic [2:0] c_OP_BNOT = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          w_busy;
  logic          w_done;

  logic [6:0]    r_mem [PROG_DEPTH];
  logic [AW-1:0] r_pc;
  logic [15:0]   r_reg [4];
  logic [15:0]   r_y   [4];

  logic [6:0]    w_instr;
  logic [2:0]    w_op;
  logic [1:0]    w_dst;
  logic [1:0]    w_src;
  logic [15:0]   w_rd;
  logic [15:0]   w_rs;
  logic [15:0]   w_res;
  logic          w_wr_en;
  logic          w_last;
  logic [15:0]   w_reg_next [4];

  // Program memory is deliberately unreset; writes only land while idle so a
  // running program can never be altered underneath the sequencer.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.prog_we) begin
      r_mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  always_comb begin
    w_instr = r_mem[r_pc];
    w_op    = w_instr[6:4];
    w_dst   = w_instr[3:2];
    w_src   = w_instr[1:0];
    w_rd    = r_reg[w_dst];
    w_rs    = r_reg[w_src];
    w_res   = w_rd;
    w_wr_en = 1'b1;
    case (w_op)
      c_OP_NOP:  w_wr_en = 1'b0;
      c_OP_MOV:  w_res   = w_rs;
      c_OP_LNOT: w_res   = {15'b0, (w_rs == 16'h0000)};
      c_OP_OR:   w_res   = w_rd | w_rs;
      c_OP_AND:  w_res   = w_rd & w_rs;
      c_OP_XOR:  w_res   = w_rd ^ w_rs;
      c_OP_HALT: w_wr_en = 1'b0;
      c_OP_BNOT: w_res   = ~w_rs;
      default:   w_wr_en = 1'b0;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_reg_next[i] = r_reg[i];
      if (w_wr_en && (w_dst == 2'(i))) begin
        w_reg_next[i] = w_res;
      end
    end
  end

  // No pc wrap: the last slot terminates the run even without a HALT.
  assign w_last = (w_op == c_OP_HALT) || (r_pc == AW'(PROG_DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_busy       = 1'b1;
        w_state_next = S_EXEC;
      end
      S_EXEC: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_busy       = 1'b1;
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
      for (int i = 0; i < 4; i++) begin
        r_reg[i] <= '0;
        r_y[i]   <= '0;
      end
    end else begin
      case (r_state)
        S_LOAD: begin
          r_pc     <= '0;
          r_reg[0] <= bus.a0;
          r_reg[1] <= bus.a1;
          r_reg[2] <= bus.b0;
          r_reg[3] <= bus.b1;
        end
        S_EXEC: begin
          r_pc <= r_pc + AW'(1);
          for (int i = 0; i < 4; i++) begin
            r_reg[i] <= w_reg_next[i];
          end
          // Results are published with the post-instruction view of the final op.
          if (w_last) begin
            for (int i = 0; i < 4; i++) begin
              r_y[i] <= w_reg_next[i];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.y0   = r_y[0];
  assign bus.y1   = r_y[1];
  assign bus.y2   = r_y[2];
  assign bus.y3   = r_y[3];

endmodule
`default_nettype wire

// File: tb/tb_regop_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_regop_sequencer                                                |
// | Desc   : Directed plus random runs against a program-level reference model.|
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_regop_sequencer;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [6:0]  model_mem [DEPTH];
  logic [15:0] exp_y [4];
  int          exp_n;
  logic [15:0] prev_y [4];

  regop_sequencer_if #(.PROG_DEPTH(DEPTH)) bus ();

  regop_sequencer #(.PROG_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] obs_y(input int i);
    case (i)
      0:       return bus.y0;
      1:       return bus.y1;
      2:       return bus.y2;
      default: return bus.y3;
    endcase
  endfunction

  // Straight interpretation of the program: registers as an array, stop on
  // HALT or after the final slot.
  function automatic void ref_run(input logic [15:0] a0v, a1v, b0v, b1v);
    logic [15:0] r [4];
    logic [2:0]  op;
    int          d, s;
    r[0] = a0v; r[1] = a1v; r[2] = b0v; r[3] = b1v;
    exp_n = 0;
    for (int pc = 0; pc < DEPTH; pc++) begin
      op = model_mem[pc][6:4];
      d  = int'(model_mem[pc][3:2]);
      s  = int'(model_mem[pc][1:0]);
      exp_n++;
      if (op == 3'd6) break;
      case (op)
        3'd1: r[d] = r[s];
        3'd2: r[d] = (r[s] == 16'd0) ? 16'd1 : 16'd0;
        3'd3: r[d] = r[d] | r[s];
        3'd4: r[d] = r[d] & r[s];
        3'd5: r[d] = r[d] ^ r[s];
        3'd7: r[d] = ~r[s];
        default: ;
      endcase
    end
    for (int i = 0; i < 4; i++) exp_y[i] = r[i];
  endfunction

  task automatic write_prog(input int addr, input logic [6:0] data);
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = AW'(addr);
    bus.prog_data = data;
    @(posedge clk);
    #1;
    bus.prog_we = 1'b0;
    model_mem[addr] = data;
  endtask

  // mode 0: plain run; 1: start and prog_we pulsed during EXEC; 2: reset mid-run
  task automatic run(input string tag, input logic [15:0] a0v, a1v, b0v, b1v,
                     input int mode, input bit do_wr, input int wa, input logic [6:0] wd);
    int done_c, busy_c, pulses;
    bit held;
    @(negedge clk);
    bus.a0 = a0v; bus.a1 = a1v; bus.b0 = b0v; bus.b1 = b1v;
    bus.start = 1'b1;
    if (do_wr) begin
      bus.prog_we = 1'b1; bus.prog_addr = AW'(wa); bus.prog_data = wd;
      model_mem[wa] = wd;
    end
    ref_run(a0v, a1v, b0v, b1v);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.prog_we = 1'b0;
    done_c = -1; busy_c = 0; pulses = 0; held = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.busy) busy_c++;
      if (bus.done) begin
        pulses++;
        if (done_c < 0) done_c = c;
      end
      if (done_c < 0) begin
        for (int i = 0; i < 4; i++) if (obs_y(i) !== prev_y[i]) held = 1'b0;
      end
      if (c == 1) begin
        bus.a0 = 16'($urandom); bus.a1 = 16'($urandom);
        bus.b0 = 16'($urandom); bus.b1 = 16'($urandom);
      end
      if (mode == 1 && c == 2) begin
        bus.start = 1'b1; bus.prog_we = 1'b1;
        bus.prog_addr = '0; bus.prog_data = 7'h60;
      end
      if (mode == 1 && c == 3) begin
        bus.start = 1'b0; bus.prog_we = 1'b0;
      end
      if (mode == 2 && c == 3) begin
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_y0"}, 32'(bus.y0), 32'h0);
        check({tag, "_rst_y3"}, 32'(bus.y3), 32'h0);
        check({tag, "_rst_busy"}, 32'(bus.busy), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_rst_done"}, 32'(bus.done), 32'h0);
        check({tag, "_rst_pulses"}, 32'(pulses), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) prev_y[i] = '0;
        break;
      end
      if (done_c >= 0 && c >= done_c + 2) break;
    end
    if (mode != 2) begin
      check({tag, "_done_cycle"}, 32'(done_c), 32'(exp_n + 1));
      check({tag, "_busy_cycles"}, 32'(busy_c), 32'(exp_n + 2));
      check({tag, "_pulses"}, 32'(pulses), 32'h1);
      check({tag, "_y_held"}, 32'(held), 32'h1);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("%s_y%0d", tag, i), 32'(obs_y(i)), 32'(exp_y[i]));
        prev_y[i] = exp_y[i];
      end
    end
  endtask

  initial begin
    logic [2:0] op;
    int         h;
    checks = 0; errors = 0;
    rst_n = 1'b0;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0; bus.start = 1'b0;
    bus.a0 = '0; bus.a1 = '0; bus.b0 = '0; bus.b1 = '0;
    for (int i = 0; i < 4; i++) prev_y[i] = '0;
    #3;
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_done", 32'(bus.done), 32'h0);
    check("reset_y0", 32'(bus.y0), 32'h0);
    check("reset_y3", 32'(bus.y3), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) write_prog(i, 7'h00);
    write_prog(0, 7'b010_11_00);
    write_prog(1, 7'b010_00_00);
    write_prog(2, 7'b011_00_11);
    write_prog(3, 7'b101_10_10);
    write_prog(4, 7'b100_11_01);
    write_prog(5, 7'b110_00_00);

    run("t1", 16'h0000, 16'hFFFF, 16'h1234, 16'h5678, 0, 1'b0, 0, 7'h0);
    check("t1_const_y3", 32'(bus.y3), 32'h0001);
    check("t1_const_y1", 32'(bus.y1), 32'hFFFF);
    run("t2", 16'h0005, 16'h00F0, 16'h1234, 16'h5678, 0, 1'b0, 0, 7'h0);
    check("t2_const_y1", 32'(bus.y1), 32'h00F0);
    run("t3_disturb", 16'h0000, 16'hFFFF, 16'h1234, 16'h5678, 1, 1'b0, 0, 7'h0);
    run("t3_rerun", 16'h0000, 16'hFFFF, 16'h1234, 16'h5678, 0, 1'b0, 0, 7'h0);
    check("t3_rerun_y3", 32'(bus.y3), 32'h0001);

    for (int i = 0; i < DEPTH; i++) write_prog(i, 7'h00);
    run("t4_nop", 16'hA0A0, 16'hA1A1, 16'hB0B0, 16'hB1B1, 0, 1'b0, 0, 7'h0);
    check("t4_const_y2", 32'(bus.y2), 32'hB0B0);

    write_prog(0, 7'b111_01_00);
    write_prog(1, 7'b001_10_01);
    write_prog(2, 7'b110_00_00);
    run("t5_bnot", 16'h00FF, 16'h1111, 16'h2222, 16'h3333, 0, 1'b0, 0, 7'h0);
    check("t5_const_y1", 32'(bus.y1), 32'hFF00);
    check("t5_const_y2", 32'(bus.y2), 32'hFF00);
    check("t5_const_y3", 32'(bus.y3), 32'h3333);

    run("t6_wr_start", 16'h00FF, 16'h1111, 16'h2222, 16'h3333, 0, 1'b1, 0, 7'b101_00_01);

    write_prog(0, 7'b010_11_00);
    write_prog(1, 7'b010_00_00);
    write_prog(2, 7'b011_00_11);
    write_prog(3, 7'b101_10_10);
    write_prog(4, 7'b100_11_01);
    write_prog(5, 7'b110_00_00);
    run("t7_reset", 16'h0000, 16'hFFFF, 16'h1234, 16'h5678, 2, 1'b0, 0, 7'h0);
    run("t7_after", 16'h0000, 16'hFFFF, 16'h1234, 16'h5678, 0, 1'b0, 0, 7'h0);

    for (int k = 0; k < 6; k++) begin
      h = int'($urandom_range(1, DEPTH));
      for (int i = 0; i < DEPTH; i++) begin
        op = 3'($urandom_range(0, 6));
        if (op == 3'd6) op = 3'd7;
        if (i == h) op = 3'd6;
        write_prog(i, {op, 4'($urandom)});
      end
      run($sformatf("rnd%0d", k), 16'($urandom), 16'($urandom), 16'($urandom),
          16'($urandom), 0, 1'b0, 0, 7'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
